// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Hazard controller for a 5-stage in-order pipeline. Detects
//            RAW hazards against shadow copies of the EX/MEM/WB stages,
//            produces stall/flush/bubble controls and registered operand
//            forwarding selects, and drains the pipe on a halt instruction.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int FWD_EN   = 1,
  parameter int BR_STAGE = 2,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_mr,
  input  logic              id_hlt,
  input  logic              br_taken,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              flush_if_id,
  output logic              id_ex_bubble,
  output logic              ex_kill,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              halted
);

  // Shadow record of the instruction occupying a downstream stage
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              mr;
    logic              hlt;
  } rec_t;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  rec_t       ex_q, ex_d;
  rec_t       mem_q, mem_d;
  rec_t       wb_q, wb_d;
  logic [1:0] state_q, state_d;
  logic [1:0] fwd_a_q, fwd_a_d;
  logic [1:0] fwd_b_q, fwd_b_d;

  logic rs_ex, rt_ex, rs_mem, rt_mem;
  logic hit_ex, hit_mem;
  logic stall_raw, stall, flush;

  // A source depends on a record when that record will write the register
  // being read; register 0 is exempt when it is hardwired.
  function automatic logic f_match(input logic [REG_AW-1:0] s,
                                   input logic              used,
                                   input rec_t              r);
    return r.v & r.wr & (r.rd == s) & used & ~((ZERO_REG != 0) && (s == '0));
  endfunction

  // Hazard detection: source/record matches, raw stall, branch flush
  always_comb begin
    rs_ex   = id_valid & f_match(id_rs, id_rs_used, ex_q);
    rt_ex   = id_valid & f_match(id_rt, id_rt_used, ex_q);
    rs_mem  = id_valid & f_match(id_rs, id_rs_used, mem_q);
    rt_mem  = id_valid & f_match(id_rt, id_rt_used, mem_q);
    hit_ex  = rs_ex | rt_ex;
    hit_mem = rs_mem | rt_mem;
    if (FWD_EN != 0) begin
      // only a load in EX cannot be forwarded in time
      stall_raw = hit_ex & ex_q.mr;
    end else begin
      // WB needs no stall because the regfile writes through
      stall_raw = hit_ex | hit_mem;
    end
    // a halted core ignores branches; a flush discards any pending stall
    flush = br_taken & (state_q != ST_HALTED);
    stall = stall_raw & (state_q == ST_RUN) & ~flush;
  end

  // Halt FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Halt FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (id_valid & id_hlt & ~stall & ~flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ex_kill & ex_q.v & ex_q.hlt) begin
          state_d = ST_RUN;
        end else if (wb_q.v & wb_q.hlt) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Pipeline control outputs: flush beats drain/halt/stall freezing
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    flush_if_id  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_kill      = 1'b0;
    if (flush) begin
      flush_if_id  = 1'b1;
      id_ex_bubble = 1'b1;
      ex_kill      = (BR_STAGE == 3);
    end else if ((state_q != ST_RUN) || stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  // Shadow pipeline advance and forwarding select computation
  always_comb begin
    if (id_ex_bubble) begin
      ex_d = '0;
    end else begin
      ex_d.v   = id_valid;
      ex_d.rd  = id_rd;
      ex_d.wr  = id_wr;
      ex_d.mr  = id_mr;
      ex_d.hlt = id_hlt;
    end
    mem_d = ex_kill ? '0 : ex_q;
    wb_d  = mem_q;

    fwd_a_d = SEL_RF;
    fwd_b_d = SEL_RF;
    if (!id_ex_bubble && (FWD_EN != 0)) begin
      // the youngest producer (EX) wins over MEM
      if (rs_ex & ~ex_q.mr) begin
        fwd_a_d = SEL_EX;
      end else if (rs_mem) begin
        fwd_a_d = SEL_MEM;
      end
      if (rt_ex & ~ex_q.mr) begin
        fwd_b_d = SEL_EX;
      end else if (rt_mem) begin
        fwd_b_d = SEL_MEM;
      end
    end
  end

  // Shadow records and forwarding select registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= SEL_RF;
      fwd_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a  = fwd_a_q;
  assign fwd_b  = fwd_b_q;
  assign halted = (state_q == ST_HALTED);

  // Record fields kept for completeness but not needed by the control logic
  logic unused_fields;
  assign unused_fields = ^{mem_q.mr, mem_q.hlt, wb_q.rd, wb_q.wr, wb_q.mr};

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Scoreboard bench for pipe_hazard_ctrl. Three instances share
//            the stimulus: A = forwarding/EX branch, B = stall-only,
//            C = forwarding/MEM branch. Each cycle the driver queues the
//            hand-derived output vector per instance; a negedge monitor
//            pops and compares.
// Revision : 1.1 - reset-state check and run watchdog
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int C_TIMEOUT_NS = 100000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_rs_used, id_rt_used, id_wr, id_mr, id_hlt, br_taken;
    logic [3:0] id_rs, id_rt, id_rd;

    logic [2:0] pcw, ifw, fl, bub, kl, hl;
    logic [1:0] fa [3];
    logic [1:0] fb [3];

    logic       r_done = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(4), .FWD_EN(1), .BR_STAGE(2), .ZERO_REG(1)) u_a (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
        .id_mr(id_mr), .id_hlt(id_hlt), .br_taken(br_taken), .pc_write(pcw[0]),
        .if_id_write(ifw[0]), .flush_if_id(fl[0]), .id_ex_bubble(bub[0]), .ex_kill(kl[0]),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .halted(hl[0]));

    pipe_hazard_ctrl #(.REG_AW(4), .FWD_EN(0), .BR_STAGE(2), .ZERO_REG(1)) u_b (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
        .id_mr(id_mr), .id_hlt(id_hlt), .br_taken(br_taken), .pc_write(pcw[1]),
        .if_id_write(ifw[1]), .flush_if_id(fl[1]), .id_ex_bubble(bub[1]), .ex_kill(kl[1]),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .halted(hl[1]));

    pipe_hazard_ctrl #(.REG_AW(4), .FWD_EN(1), .BR_STAGE(3), .ZERO_REG(1)) u_c (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rd(id_rd), .id_wr(id_wr),
        .id_mr(id_mr), .id_hlt(id_hlt), .br_taken(br_taken), .pc_write(pcw[2]),
        .if_id_write(ifw[2]), .flush_if_id(fl[2]), .id_ex_bubble(bub[2]), .ex_kill(kl[2]),
        .fwd_a(fa[2]), .fwd_b(fb[2]), .halted(hl[2]));

    // Output vector layout: {pc_write, if_id_write, flush, bubble, ex_kill, fwd_a, fwd_b, halted}
    localparam logic [9:0] N00 = 10'b11000_00_00_0;  // normal flow, no forwarding
    localparam logic [9:0] S00 = 10'b00010_00_00_0;  // stall / drain freeze
    localparam logic [9:0] FL  = 10'b11110_00_00_0;  // branch flush
    localparam logic [9:0] FLK = 10'b11111_00_00_0;  // branch flush with EX kill
    localparam logic [9:0] HLT = 10'b00010_00_00_1;  // halted

    typedef struct {
        int         dut;
        int         step;
        logic [9:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_n = 0;

    function automatic logic [9:0] nv(input logic [1:0] a, input logic [1:0] b);
        return {5'b11000, a, b, 1'b0};
    endfunction

    function automatic logic [9:0] outs(input int d);
        return {pcw[d], ifw[d], fl[d], bub[d], kl[d], fa[d], fb[d], hl[d]};
    endfunction

    // Monitor: compare every queued expectation against the sampled outputs
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [9:0] got;
            e   = exp_q.pop_front();
            got = outs(e.dut);
            checks++;
            if (got !== e.vec) begin
                errors++;
                $display("FAIL step %0d dut %0d outs{pcw,ifw,fl,bub,kill,fa,fb,hlt}: got %b exp %b",
                         e.step, e.dut, got, e.vec);
            end
        end
    end

    // Watchdog: the stimulus must complete within a bounded time
    initial begin
        #(C_TIMEOUT_NS);
        if (!r_done) begin
            errors++;
            $display("FAIL timeout: stimulus did not complete within %0d ns", C_TIMEOUT_NS);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Reset-state check: while rst_n is low every instance shows the idle vector
    task automatic check_reset();
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (outs(d) !== N00) begin
                errors++;
                $display("FAIL reset state step %0d dut %0d: got %b exp %b",
                         step_n, d, outs(d), N00);
            end
        end
    endtask

    task automatic id_set(input logic v, input logic [3:0] rs, input logic rsu,
                          input logic [3:0] rt, input logic rtu, input logic [3:0] rd,
                          input logic wr, input logic mr, input logic hlt, input logic br);
        id_valid = v;  id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_rd = rd;    id_wr = wr; id_mr = mr;       id_hlt = hlt; br_taken = br;
    endtask

    task automatic nop();
        id_set(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Queue expectations for A, B, C for the current cycle, then advance
    task automatic step(input logic [9:0] ea, input logic [9:0] eb, input logic [9:0] ec);
        exp_q.push_back('{0, step_n, ea});
        exp_q.push_back('{1, step_n, eb});
        exp_q.push_back('{2, step_n, ec});
        @(posedge clk);
        #1;
        step_n++;
    endtask

    // Asynchronous reset for one cycle, asserted away from the clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        nop();
        #1;
        check_reset();
        step(N00, N00, N00);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        @(posedge clk);
        #1;

        // Load-use: LD r3, ADD r4=r3+r2
        do_reset();
        id_set(1, 4'd1, 1, 4'd0, 0, 4'd3, 1, 1, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd3, 1, 4'd2, 1, 4'd4, 1, 0, 0, 0); step(S00, S00, S00);
        step(N00, S00, N00);
        nop(); step(nv(2'b10, 2'b00), N00, nv(2'b10, 2'b00));

        // Back-to-back ALU: ADD r5; SUB r6=r1-r5
        do_reset();
        id_set(1, 4'd1, 1, 4'd2, 1, 4'd5, 1, 0, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd1, 1, 4'd5, 1, 4'd6, 1, 0, 0, 0); step(N00, S00, N00);
        nop(); step(nv(2'b00, 2'b01), N00, nv(2'b00, 2'b01));
        step(N00, N00, N00);

        // ALU with intervening NOP
        do_reset();
        id_set(1, 4'd1, 1, 4'd2, 1, 4'd5, 1, 0, 0, 0); step(N00, N00, N00);
        nop(); step(N00, N00, N00);
        id_set(1, 4'd1, 1, 4'd5, 1, 4'd6, 1, 0, 0, 0); step(N00, S00, N00);
        nop(); step(nv(2'b00, 2'b10), N00, nv(2'b00, 2'b10));

        // Stall-only mode: SUB held in ID for two stall cycles
        do_reset();
        id_set(1, 4'd1, 1, 4'd2, 1, 4'd5, 1, 0, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd1, 1, 4'd5, 1, 4'd6, 1, 0, 0, 0); step(N00, S00, N00);
        step(nv(2'b00, 2'b01), S00, nv(2'b00, 2'b01));
        step(nv(2'b00, 2'b10), N00, nv(2'b00, 2'b10));
        nop(); step(N00, N00, N00);

        // Zero register never hazards; invalid ID never stalls or forwards
        do_reset();
        id_set(1, 4'd1, 1, 4'd0, 0, 4'd0, 1, 1, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd0, 1, 4'd0, 1, 4'd7, 1, 0, 0, 0); step(N00, N00, N00);
        nop(); step(N00, N00, N00);
        id_set(1, 4'd1, 1, 4'd0, 0, 4'd3, 1, 1, 0, 0); step(N00, N00, N00);
        id_set(0, 4'd3, 1, 4'd3, 1, 4'd4, 1, 0, 0, 0); step(N00, N00, N00);
        nop(); step(N00, N00, N00);

        // Stall and taken branch together: flush wins; MEM-branch also kills EX
        do_reset();
        id_set(1, 4'd1, 1, 4'd0, 0, 4'd3, 1, 1, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd3, 1, 4'd0, 0, 4'd4, 1, 0, 0, 1); step(FL, FL, FLK);
        id_set(1, 4'd3, 1, 4'd0, 0, 4'd4, 1, 0, 0, 0); step(N00, S00, N00);
        nop(); step(nv(2'b10, 2'b00), N00, N00);

        // Halt behind ADD r2: 3 drain cycles, then sticky halt ignoring branches
        do_reset();
        id_set(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 0, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0); step(N00, N00, N00);
        nop(); step(S00, S00, S00);
        step(S00, S00, S00);
        step(S00, S00, S00);
        id_set(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1); step(HLT, HLT, HLT);
        step(HLT, HLT, HLT);

        // Taken branch while halt is in EX: only the MEM-branch instance resumes
        do_reset();
        id_set(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 0, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0); step(N00, N00, N00);
        id_set(0, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 1); step(FL, FL, FLK);
        nop(); step(S00, S00, N00);
        step(S00, S00, N00);
        step(HLT, HLT, N00);
        step(HLT, HLT, N00);

        // Reset mid-drain, then reset mid-stall: nothing survives
        do_reset();
        id_set(1, 4'd1, 1, 4'd0, 0, 4'd2, 1, 0, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0); step(N00, N00, N00);
        nop(); step(S00, S00, S00);
        do_reset();
        step(N00, N00, N00);
        step(N00, N00, N00);
        step(N00, N00, N00);
        id_set(1, 4'd1, 1, 4'd0, 0, 4'd3, 1, 1, 0, 0); step(N00, N00, N00);
        id_set(1, 4'd3, 1, 4'd0, 0, 4'd4, 1, 0, 0, 0); step(S00, S00, S00);
        do_reset();
        id_set(1, 4'd3, 1, 4'd0, 0, 4'd4, 1, 0, 0, 0); step(N00, N00, N00);
        nop(); step(N00, N00, N00);

        @(negedge clk);
        #1;
        r_done = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- REG_AW, 4, register-address width.
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode.
- BR_STAGE, 2, branch-resolve stage: 2 = EX, 3 = MEM.
- ZERO_REG, 1, 1 = register 0 is hardwired and never creates a hazard.
REQ-002 Clock and reset: clk, rst_n. Reset rst_n is asynchronous, active-low; clock clk.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  clock.
- rst_n  in  1  reset.
- id_valid  in  1  instruction valid in ID.
- id_rs, id_rt  in  REG_AW  source registers.
- id_rs_used, id_rt_used  in  1  source is read.
- id_rd  in  REG_AW  destination register.
- id_wr  in  1  instruction writes the register file.
- id_mr  in  1  instruction is a load.
- id_hlt  in  1  instruction is a halt.
- br_taken  in  1  taken branch in stage BR_STAGE.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- flush_if_id  out  1  clear IF/ID.
- id_ex_bubble  out  1  insert a NOP into ID/EX.
- ex_kill  out  1  squash EX->MEM; always 0 when BR_STAGE=2.
- fwd_a, fwd_b  out  2  registered EX operand select: 00 = regfile, 01 = EX/MEM result, 10 = MEM/WB data.
- halted  out  1  sticky halt indication.

Function
REQ-004 Shadow records EXr, MEMr, WBr SHALL each hold {v, rd, wr, mr, hlt}.
REQ-005 Every clk: EXr <= bubble if id_ex_bubble, else ID fields with v=id_valid; MEMr <= bubble if ex_kill, else EXr; WBr <= MEMr.
REQ-006 match(s, R) is true iff R.v & R.wr & (R.rd == s) & source-used & ~(ZERO_REG & s == 0).
REQ-007 FWD_EN=1: stall = id_valid & match against EXr with EXr.mr = 1 (load-use), 1-cycle bubble.
REQ-008 FWD_EN=0: stall = id_valid & match against EXr or MEMr; WB is covered by regfile write-through.
REQ-009 While stalled: pc_write=0, if_id_write=0, id_ex_bubble=1.
REQ-010 fwd_a/fwd_b SHALL be registered on every clk when no bubble is inserted: 01 if match EXr (non-load), else 10 if match MEMr, else 00. Bubble or FWD_EN=0 SHALL load 00. EX priority is over MEM.
REQ-011 br_taken (BR_STAGE=2): flush_if_id=1, id_ex_bubble=1, pc_write=1, if_id_write=1.
REQ-012 br_taken (BR_STAGE=3): same as REQ-011, plus ex_kill=1.
REQ-013 Flush SHALL take priority over stall in the same cycle; the stall is dropped.
REQ-014 Halt FSM states RUN, DRAIN, HALTED.
REQ-015 RUN->DRAIN when a valid id_hlt instruction moves into EXr, with no stall and no flush.
REQ-016 DRAIN: pc_write=0, if_id_write=0, id_ex_bubble=1.
REQ-017 DRAIN->RUN if ex_kill squashes the halt instruction.
REQ-018 DRAIN->HALTED on the clk where WBr.hlt & WBr.v.
REQ-019 HALTED: halted=1, pc_write=0, if_id_write=0, id_ex_bubble=1, until reset; br_taken is ignored.
REQ-020 id_valid=0 SHALL never create a stall or a forward.

Reset
REQ-021 rst_n low SHALL asynchronously set:
- all shadow records v=0.
- FSM = RUN.
- fwd_a = fwd_b = 00.
- halted = 0.
REQ-022 After rst_n low with id_valid=0 and br_taken=0, the outputs SHALL be pc_write=1, if_id_write=1, flush_if_id=0, id_ex_bubble=0, ex_kill=0.
REQ-023 Reset asserted mid-stall or mid-DRAIN SHALL abort the operation; no state is retained.

Verification
REQ-024 Load-use, FWD_EN=1: LD r3; next ADD rs=r3 -> exactly 1 stall cycle, then fwd_a=10 while ADD is in EX.
REQ-025 Back-to-back ALU: ADD r5; next SUB rt=r5 -> no stall, fwd_b=01. With intervening NOP -> fwd_b=10.
REQ-026 FWD_EN=0, same sequence as REQ-025 -> 2 stall cycles, fwd_b=00.
REQ-027 ZERO_REG=1, producer rd=0 and consumer rs=0 -> no stall, fwd=00.
REQ-028 Stall and br_taken in the same cycle: flush wins, pc_write=1, EXr bubble. BR_STAGE=3 also gives ex_kill=1.
REQ-029 HLT issued behind ADD r2 -> DRAIN for 3 cycles, halted=1 on the 4th, stays 1 under br_taken. BR_STAGE=3 with taken branch in MEM while HLT is in EX -> back to RUN, halted=0.
